apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem_if.sv | 22 ++
 rtl/apb_slave_mem.sv | 104 ++++++++++
 tb/tb_apb_slave_mem.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a bridge (master) and the byte-wide memory slave.
// The clock and reset stay as plain ports on the slave.
interface apb_slave_mem_if;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave backed by a byte-wide register memory, with programmable wait states,
// address-range and mid-transfer protocol error detection, and a saturating error counter.
module apb_slave_mem #(
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   apb_slave_mem_if.slave       apb,
   output logic [7:0]           err_count
);

   localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [8:0] DEPTH     = 9'(MEM_DEPTH);
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0] state;
   logic [3:0] wcnt;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] prdata_q;
   logic       write_q;
   logic       range_err;
   logic       proto_err;

   logic [7:0] mem [MEM_DEPTH];

   logic       setup;
   logic       in_range;
   logic [7:0] rd_word;
   logic       ready;
   logic       slverr;
   logic       field_mismatch;
   logic       mem_we;

   // A setup phase (PSEL without PENABLE) restarts a transfer from either state.
   assign setup          = apb.PSEL && !apb.PENABLE;
   assign in_range       = {1'b0, apb.PADDR} < DEPTH;
   assign rd_word        = in_range ? mem[apb.PADDR[AW-1:0]] : 8'h00;
   assign ready          = (state == ACCESS) && (wcnt == WAIT_LAST);
   assign slverr         = ready && (range_err || proto_err);
   assign field_mismatch = (apb.PADDR != addr_q) || (apb.PWRITE != write_q) ||
                           (write_q && (apb.PWDATA != wdata_q));
   assign mem_we         = (state == ACCESS) && apb.PSEL && apb.PENABLE && ready &&
                           write_q && !range_err && !proto_err;

   assign apb.PREADY  = ready;
   assign apb.PSLVERR = slverr;
   assign apb.PRDATA  = prdata_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         wcnt      <= 4'd0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         write_q   <= 1'b0;
         prdata_q  <= 8'h00;
         range_err <= 1'b0;
         proto_err <= 1'b0;
         err_count <= 8'h00;
      end else if (setup) begin
         state     <= ACCESS;
         wcnt      <= 4'd0;
         addr_q    <= apb.PADDR;
         wdata_q   <= apb.PWDATA;
         write_q   <= apb.PWRITE;
         range_err <= !in_range;
         proto_err <= 1'b0;
         if (!apb.PWRITE)
            prdata_q <= rd_word;
      end else if (state == ACCESS) begin
         if (!apb.PSEL) begin
            state <= IDLE;
            wcnt  <= 4'd0;
         end else if (ready) begin
            state <= IDLE;
            if (slverr && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end else begin
            // A bus that wobbles during wait states poisons the transfer; reads then return zero.
            wcnt <= wcnt + 4'd1;
            if (field_mismatch) begin
               proto_err <= 1'b1;
               if (!write_q)
                  prdata_q <= 8'h00;
            end
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < MEM_DEPTH; i++)
            mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[addr_q[AW-1:0]] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a two-wait-state instance for most scenarios
// and a zero-wait-state instance for back-to-back transfers.
module tb_apb_slave_mem;

   logic       PCLK;
   logic       PRESETn;
   logic [7:0] err_count_slow;
   logic [7:0] err_count_fast;

   int         checks;
   int         errors;

   int         cyc;
   logic       err;
   logic [7:0] rd;

   apb_slave_mem_if bus_slow ();
   apb_slave_mem_if bus_fast ();

   apb_slave_mem #(.MEM_DEPTH(64), .WAIT_CYCLES(2)) dut_slow (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .apb       (bus_slow.slave),
      .err_count (err_count_slow)
   );

   apb_slave_mem #(.MEM_DEPTH(64), .WAIT_CYCLES(0)) dut_fast (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .apb       (bus_fast.slave),
      .err_count (err_count_fast)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
      end
   endtask

   task automatic busIdle();
      @(negedge PCLK);
      bus_slow.PSEL    = 1'b0;
      bus_slow.PENABLE = 1'b0;
   endtask

   // Setup phase then access phase until PREADY; returns at the negedge where PREADY is seen.
   task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                output int cycles, output logic slverr, output logic [7:0] rdata);
      @(negedge PCLK);
      bus_slow.PSEL    = 1'b1;
      bus_slow.PENABLE = 1'b0;
      bus_slow.PWRITE  = wr;
      bus_slow.PADDR   = addr;
      bus_slow.PWDATA  = data;
      @(negedge PCLK);
      bus_slow.PENABLE = 1'b1;
      cycles = 1;
      while (!bus_slow.PREADY && cycles < 20) begin
         @(negedge PCLK);
         cycles++;
      end
      if (!bus_slow.PREADY) begin
         cycles = 99;
         slverr = 1'b0;
         rdata  = 8'h00;
      end else begin
         slverr = bus_slow.PSLVERR;
         rdata  = bus_slow.PRDATA;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      PRESETn = 1'b1;
      bus_slow.PSEL = 1'b0; bus_slow.PENABLE = 1'b0; bus_slow.PWRITE = 1'b0;
      bus_slow.PADDR = 8'h00; bus_slow.PWDATA = 8'h00;
      bus_fast.PSEL = 1'b0; bus_fast.PENABLE = 1'b0; bus_fast.PWRITE = 1'b0;
      bus_fast.PADDR = 8'h00; bus_fast.PWDATA = 8'h00;

      #2 PRESETn = 1'b0;
      #1;
      checkOutput("rst_pready",    {7'b0, bus_slow.PREADY},  8'h00);
      checkOutput("rst_pslverr",   {7'b0, bus_slow.PSLVERR}, 8'h00);
      checkOutput("rst_prdata",    bus_slow.PRDATA,          8'h00);
      checkOutput("rst_err_count", err_count_slow,           8'h00);
      checkOutput("rst_fast_pready", {7'b0, bus_fast.PREADY}, 8'h00);
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;

      // Basic write with two wait states, then read back
      applyStimulus(1'b1, 8'h03, 8'h5A, cyc, err, rd);
      checkOutput("wr03_cycles", 8'(cyc), 8'd3);
      checkOutput("wr03_slverr", {7'b0, err}, 8'h00);
      busIdle();
      applyStimulus(1'b0, 8'h03, 8'h00, cyc, err, rd);
      checkOutput("rd03_cycles", 8'(cyc), 8'd3);
      checkOutput("rd03_slverr", {7'b0, err}, 8'h00);
      checkOutput("rd03_data",   rd, 8'h5A);
      busIdle();

      // Read set up directly after a write completion sees fresh data
      applyStimulus(1'b1, 8'h04, 8'hA5, cyc, err, rd);
      applyStimulus(1'b0, 8'h04, 8'h00, cyc, err, rd);
      checkOutput("b2b_rd04_data", rd, 8'hA5);
      busIdle();

      // Highest legal address
      applyStimulus(1'b1, 8'h3F, 8'hC3, cyc, err, rd);
      checkOutput("wr3f_slverr", {7'b0, err}, 8'h00);
      busIdle();
      applyStimulus(1'b0, 8'h3F, 8'h00, cyc, err, rd);
      checkOutput("rd3f_data", rd, 8'hC3);
      busIdle();

      // Out-of-range write and read
      applyStimulus(1'b1, 8'h40, 8'h77, cyc, err, rd);
      checkOutput("wr40_cycles", 8'(cyc), 8'd3);
      checkOutput("wr40_slverr", {7'b0, err}, 8'h01);
      busIdle();
      checkOutput("wr40_err_count", err_count_slow, 8'h01);
      applyStimulus(1'b0, 8'h40, 8'h00, cyc, err, rd);
      checkOutput("rd40_slverr", {7'b0, err}, 8'h01);
      checkOutput("rd40_data",   rd, 8'h00);
      busIdle();
      checkOutput("rd40_err_count", err_count_slow, 8'h02);

      // Address changes during a wait state
      applyStimulus(1'b1, 8'h05, 8'h21, cyc, err, rd);
      applyStimulus(1'b1, 8'h06, 8'h22, cyc, err, rd);
      @(negedge PCLK);
      bus_slow.PSEL = 1'b1; bus_slow.PENABLE = 1'b0; bus_slow.PWRITE = 1'b1;
      bus_slow.PADDR = 8'h05; bus_slow.PWDATA = 8'h99;
      @(negedge PCLK);
      bus_slow.PENABLE = 1'b1;
      checkOutput("proto_wait1_pready", {7'b0, bus_slow.PREADY}, 8'h00);
      @(negedge PCLK);
      bus_slow.PADDR = 8'h06;
      @(negedge PCLK);
      checkOutput("proto_pready",  {7'b0, bus_slow.PREADY},  8'h01);
      checkOutput("proto_pslverr", {7'b0, bus_slow.PSLVERR}, 8'h01);
      busIdle();
      checkOutput("proto_err_count", err_count_slow, 8'h03);
      applyStimulus(1'b0, 8'h05, 8'h00, cyc, err, rd);
      checkOutput("proto_rd05", rd, 8'h21);
      applyStimulus(1'b0, 8'h06, 8'h00, cyc, err, rd);
      checkOutput("proto_rd06", rd, 8'h22);
      busIdle();

      // PSEL dropped after one wait cycle
      @(negedge PCLK);
      bus_slow.PSEL = 1'b1; bus_slow.PENABLE = 1'b0; bus_slow.PWRITE = 1'b1;
      bus_slow.PADDR = 8'h07; bus_slow.PWDATA = 8'h66;
      @(negedge PCLK);
      bus_slow.PENABLE = 1'b1;
      @(negedge PCLK);
      checkOutput("abort_pready_w1", {7'b0, bus_slow.PREADY}, 8'h00);
      bus_slow.PSEL = 1'b0; bus_slow.PENABLE = 1'b0;
      @(negedge PCLK);
      checkOutput("abort_state",  {7'b0, dut_slow.state}, 8'h00);
      checkOutput("abort_pready", {7'b0, bus_slow.PREADY}, 8'h00);
      @(negedge PCLK);
      checkOutput("abort_pready_later", {7'b0, bus_slow.PREADY}, 8'h00);
      applyStimulus(1'b0, 8'h07, 8'h00, cyc, err, rd);
      checkOutput("abort_rd07", rd, 8'h00);
      busIdle();
      checkOutput("abort_err_count", err_count_slow, 8'h03);

      // Access phase without a setup phase is ignored
      @(negedge PCLK);
      bus_slow.PSEL = 1'b1; bus_slow.PENABLE = 1'b1; bus_slow.PWRITE = 1'b1;
      bus_slow.PADDR = 8'h08; bus_slow.PWDATA = 8'h12;
      @(negedge PCLK);
      checkOutput("nosetup_pready1", {7'b0, bus_slow.PREADY}, 8'h00);
      @(negedge PCLK);
      checkOutput("nosetup_pready2", {7'b0, bus_slow.PREADY}, 8'h00);
      busIdle();
      applyStimulus(1'b0, 8'h08, 8'h00, cyc, err, rd);
      checkOutput("nosetup_rd08", rd, 8'h00);
      busIdle();

      // New setup phase in the middle of an access restarts the transfer
      @(negedge PCLK);
      bus_slow.PSEL = 1'b1; bus_slow.PENABLE = 1'b0; bus_slow.PWRITE = 1'b1;
      bus_slow.PADDR = 8'h09; bus_slow.PWDATA = 8'h31;
      @(negedge PCLK);
      bus_slow.PENABLE = 1'b1;
      applyStimulus(1'b1, 8'h0A, 8'h32, cyc, err, rd);
      checkOutput("restart_cycles", 8'(cyc), 8'd3);
      checkOutput("restart_slverr", {7'b0, err}, 8'h00);
      busIdle();
      applyStimulus(1'b0, 8'h09, 8'h00, cyc, err, rd);
      checkOutput("restart_rd09", rd, 8'h00);
      applyStimulus(1'b0, 8'h0A, 8'h00, cyc, err, rd);
      checkOutput("restart_rd0a", rd, 8'h32);
      busIdle();

      // Zero wait states, back-to-back write then read
      @(negedge PCLK);
      bus_fast.PSEL = 1'b1; bus_fast.PENABLE = 1'b0; bus_fast.PWRITE = 1'b1;
      bus_fast.PADDR = 8'h00; bus_fast.PWDATA = 8'h11;
      @(negedge PCLK);
      bus_fast.PENABLE = 1'b1;
      checkOutput("fast_wr_pready",  {7'b0, bus_fast.PREADY},  8'h01);
      checkOutput("fast_wr_pslverr", {7'b0, bus_fast.PSLVERR}, 8'h00);
      @(negedge PCLK);
      bus_fast.PENABLE = 1'b0; bus_fast.PWRITE = 1'b0;
      @(negedge PCLK);
      bus_fast.PENABLE = 1'b1;
      checkOutput("fast_rd_pready", {7'b0, bus_fast.PREADY}, 8'h01);
      checkOutput("fast_rd_data",   bus_fast.PRDATA, 8'h11);
      @(negedge PCLK);
      bus_fast.PSEL = 1'b0; bus_fast.PENABLE = 1'b0;
      checkOutput("fast_idle_pready", {7'b0, bus_fast.PREADY}, 8'h00);
      checkOutput("fast_err_count", err_count_fast, 8'h00);

      // Reset asserted while PREADY is high
      @(negedge PCLK);
      bus_slow.PSEL = 1'b1; bus_slow.PENABLE = 1'b0; bus_slow.PWRITE = 1'b1;
      bus_slow.PADDR = 8'h03; bus_slow.PWDATA = 8'h44;
      @(negedge PCLK);
      bus_slow.PENABLE = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      checkOutput("prerst_pready", {7'b0, bus_slow.PREADY}, 8'h01);
      checkOutput("prerst_prdata", bus_slow.PRDATA, 8'h32);
      #2 PRESETn = 1'b0;
      #1;
      checkOutput("midrst_pready",    {7'b0, bus_slow.PREADY},  8'h00);
      checkOutput("midrst_pslverr",   {7'b0, bus_slow.PSLVERR}, 8'h00);
      checkOutput("midrst_prdata",    bus_slow.PRDATA,          8'h00);
      checkOutput("midrst_err_count", err_count_slow,           8'h00);
      bus_slow.PSEL = 1'b0; bus_slow.PENABLE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      applyStimulus(1'b0, 8'h03, 8'h00, cyc, err, rd);
      checkOutput("postrst_rd03", rd, 8'h00);
      busIdle();
      applyStimulus(1'b1, 8'h03, 8'h5B, cyc, err, rd);
      checkOutput("postrst_wr_cycles", 8'(cyc), 8'd3);
      checkOutput("postrst_wr_slverr", {7'b0, err}, 8'h00);
      applyStimulus(1'b0, 8'h03, 8'h00, cyc, err, rd);
      checkOutput("postrst_rd03_new", rd, 8'h5B);
      busIdle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
